dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: req0_i / req1_i  in  1  access request, port 0 = CPU load/store, port 1 = loader/debug.
REQ-004 SHALL have ports: we0_i / we1_i  in  1  1 = word write, 0 = word read.
REQ-005 SHALL have ports: addr0_i / addr1_i  in  32  byte address.
REQ-006 SHALL have ports: wdata0_i / wdata1_i  in  32  write data.
REQ-007 SHALL have ports: done0_o / done1_o  out  1  one-cycle completion pulse.
REQ-008 SHALL have ports: err0_o / err1_o  out  1  error flag, valid only with done.
REQ-009 SHALL have ports: rdata0_o / rdata1_o  out  32  read data, valid only with done.
REQ-010 SHALL have ports: mem_ce_o, mem_we_o  out  1  memory enable and write enable.
REQ-011 SHALL have ports: mem_addr_o, mem_wdata_o  out  32  memory address and write data.
REQ-012 SHALL have port: mem_rdata_i  in  32  combinational memory read data.

Function
REQ-013 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, one state per cycle.
REQ-014 SHALL, in IDLE with any req high, select a port, latch its we/addr/wdata, and move to ACCESS.
REQ-015 SHALL stay in IDLE while both req are low; mem_ce_o SHALL be 0 in IDLE and RESP.
REQ-016 SHALL, in ACCESS for a legal request, drive mem_ce_o=1 and the latched mem_we_o/mem_addr_o/mem_wdata_o; on a read, capture mem_rdata_i into the selected rdata register at the ACCESS->RESP edge.
REQ-017 SHALL treat a request as illegal if addr[1:0]!=0 or addr>32'h3FC; an illegal request SHALL keep mem_ce_o=0 in ACCESS, return rdata=0, and set err=1.
REQ-018 SHALL, in RESP, pulse done for the selected port only, with err and rdata registered; the other port's done/err SHALL stay 0.
REQ-019 SHALL produce fixed latency: done is asserted 2 cycles after the IDLE cycle that accepted req; throughput is 1 access per 3 cycles.
REQ-020 SHALL ignore request inputs outside IDLE; a requester SHALL drop req in the cycle after done, and a req still high in IDLE is a new request.
REQ-021 SHALL not leave a write outstanding: the write occurs at the ACCESS->RESP clock edge.
REQ-022 SHALL hold rdata0_o/rdata1_o between accesses, updating only on that port's completed read or error.

Reset
REQ-023 SHALL, on rst=1 at any time, asynchronously force state=IDLE, all done/err=0, rdata=0, mem_ce_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, and last_grant=1.
REQ-024 SHALL abort any access on reset mid-ACCESS; no done SHALL be issued for an aborted access.

Configuration
REQ-025 SHALL, with DMEM_ARB_RR_EN defined, arbitrate round-robin: on a tie, grant the port not equal to last_grant, and update last_grant on every grant.
REQ-026 SHALL, without DMEM_ARB_RR_EN, use fixed priority: port 0 wins every tie, and last_grant is unused.

Verification
REQ-027 SHALL cover: port 0 writes 32'hDEADBEEF to 0x0C, then reads 0x0C -> second done0 has rdata0=32'hDEADBEEF, err0=0, and mem_we_o=1 only in the first ACCESS.
REQ-028 SHALL cover: both req high from reset, held until their done, with RR_EN -> grants alternate 0,1,0,1; without RR_EN -> port 0 wins while req0 stays high.
REQ-029 SHALL cover: port 1 reads addr 0x0D, then addr 0x400 -> done1 with err1=1, rdata1=0, and mem_ce_o=0 for both accesses.
REQ-030 SHALL cover: rst pulsed during ACCESS of a port 0 write -> no done0, all outputs 0 asynchronously, and the next request starts from IDLE.
REQ-031 SHALL cover: req0 toggled while port 1 is in ACCESS/RESP -> ignored, port 0 served on the next IDLE only if req0 is still high.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ACCESS -> RESP, one single-cycle word access per grant.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        we0_i,
    input  logic        we1_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    output logic        done0_o,
    output logic        done1_o,
    output logic        err0_o,
    output logic        err1_o,
    output logic [31:0] rdata0_o,
    output logic [31:0] rdata1_o,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        grant;
    logic        sel;
    logic        lat_we;
    logic        illegal;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] grant_addr;

`ifdef DMEM_ARB_RR_EN
    logic        last_grant;
`endif

    // Word-aligned and inside the 1 KiB window.
    function automatic logic is_illegal(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr > 32'h0000_03FC);
    endfunction

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (req0_i && req1_i) begin
`ifdef DMEM_ARB_RR_EN
                    grant = ~last_grant;
`else
                    grant = 1'b0;
`endif
                end else begin
                    grant = req1_i;
                end
                if (req0_i || req1_i) state_nxt = ACCESS;
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_addr = grant ? addr1_i : addr0_i;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel       <= 1'b0;
            lat_we    <= 1'b0;
            illegal   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            done0_o   <= 1'b0;
            done1_o   <= 1'b0;
            err0_o    <= 1'b0;
            err1_o    <= 1'b0;
            rdata0_o  <= '0;
            rdata1_o  <= '0;
`ifdef DMEM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            done0_o <= 1'b0;
            done1_o <= 1'b0;
            err0_o  <= 1'b0;
            err1_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_i || req1_i) begin
                        sel       <= grant;
                        lat_we    <= grant ? we1_i : we0_i;
                        lat_addr  <= grant_addr;
                        lat_wdata <= grant ? wdata1_i : wdata0_i;
                        illegal   <= is_illegal(grant_addr);
`ifdef DMEM_ARB_RR_EN
                        last_grant <= grant;
`endif
                    end
                end
                // Completion and read capture share the edge that also commits the write.
                ACCESS: begin
                    if (sel) begin
                        done1_o <= 1'b1;
                        err1_o  <= illegal;
                        if (illegal)      rdata1_o <= '0;
                        else if (!lat_we) rdata1_o <= mem_rdata_i;
                    end else begin
                        done0_o <= 1'b1;
                        err0_o  <= illegal;
                        if (illegal)      rdata0_o <= '0;
                        else if (!lat_we) rdata0_o <= mem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory strobes exist only in ACCESS, so reset silences them asynchronously via state.
    assign mem_ce_o    = (state == ACCESS) && !illegal;
    assign mem_we_o    = mem_ce_o && lat_we;
    assign mem_addr_o  = lat_addr;
    assign mem_wdata_o = lat_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected completions, a negedge monitor pops them.
// Expected grant order follows DMEM_ARB_RR_EN when the bench is built with it.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_i, req1_i, we0_i, we1_i;
    logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
    logic        done0_o, done1_o, err0_o, err1_o;
    logic [31:0] rdata0_o, rdata1_o;
    logic        mem_ce_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          done0_cnt = 0;

    logic [31:0] mem [0:255];
    bit          mem_loaded;

    dmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_i     (req0_i),
        .req1_i     (req1_i),
        .we0_i      (we0_i),
        .we1_i      (we1_i),
        .addr0_i    (addr0_i),
        .addr1_i    (addr1_i),
        .wdata0_i   (wdata0_i),
        .wdata1_i   (wdata1_i),
        .done0_o    (done0_o),
        .done1_o    (done1_o),
        .err0_o     (err0_o),
        .err1_o     (err1_o),
        .rdata0_o   (rdata0_o),
        .rdata1_o   (rdata1_o),
        .mem_ce_o   (mem_ce_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word memory: contents start as 0xA500_00nn, written on the edge that ends ACCESS.
    assign mem_rdata_i = mem[mem_addr_o[9:2]];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
            mem_loaded <= 1'b1;
        end else if (mem_ce_o && mem_we_o) begin
            mem[mem_addr_o[9:2]] <= mem_wdata_o;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (done0_o || done1_o)) begin
            if (done0_o) done0_cnt++;
            check("done_onehot", {31'd0, done0_o & done1_o}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", {31'd0, done1_o}, {31'd0, ~done1_o});
            end else begin
                mon_e = sb.pop_front();
                check("done_port", {31'd0, done1_o}, {31'd0, mon_e.port});
                check("err", {31'd0, mon_e.port ? err1_o : err0_o}, {31'd0, mon_e.err});
                check("rdata", mon_e.port ? rdata1_o : rdata0_o, mon_e.rdata);
                check("other_err", {31'd0, mon_e.port ? err0_o : err1_o}, 32'd0);
            end
        end
    end

    function automatic exp_t mk(input logic port, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rdata;
        return e;
    endfunction

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            req1_i = req; we1_i = we; addr1_i = addr; wdata1_i = wdata;
        end else begin
            req0_i = req; we0_i = we; addr0_i = addr; wdata0_i = wdata;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done0"}, {31'd0, done0_o}, 32'd0);
        check({tag, "_done1"}, {31'd0, done1_o}, 32'd0);
        check({tag, "_err0"}, {31'd0, err0_o}, 32'd0);
        check({tag, "_err1"}, {31'd0, err1_o}, 32'd0);
        check({tag, "_rdata0"}, rdata0_o, 32'd0);
        check({tag, "_rdata1"}, rdata1_o, 32'd0);
        check({tag, "_mem_ce"}, {31'd0, mem_ce_o}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we_o}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    endtask

    // Called just after a rising edge with the DUT in IDLE; returns the same way.
    task automatic access(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
        sb.push_back(mk(port, exp_err, exp_rdata));
        drive(port, 1'b1, we, addr, wdata);
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
        check("no_early_done", {30'd0, done1_o, done0_o}, 32'd0);
        check("access_ce", {31'd0, mem_ce_o}, {31'd0, ~exp_err});
        check("access_we", {31'd0, mem_we_o}, {31'd0, we & ~exp_err});
        if (!exp_err) begin
            check("access_addr", mem_addr_o, addr);
            if (we) check("access_wdata", mem_wdata_o, wdata);
        end
        @(posedge clk); #1;
        check("done_latency", {31'd0, port ? done1_o : done0_o}, 32'd1);
        check("resp_ce", {31'd0, mem_ce_o}, 32'd0);
        @(posedge clk); #1;
        check("done_single_cycle", {30'd0, done1_o, done0_o}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_zero("rst");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int saved;
        rst = 1'b0;
        req0_i = 1'b0; req1_i = 1'b0; we0_i = 1'b0; we1_i = 1'b0;
        addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
        #1;
        do_reset();

        // Write-then-read on each port; a write leaves rdata untouched.
        access(1'b0, 1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000);
        access(1'b0, 1'b0, 32'h0000_000C, 32'h0,        1'b0, 32'hDEAD_BEEF);
        access(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0000_0000);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0,        1'b0, 32'h1234_5678);
        access(1'b0, 1'b1, 32'h0000_0008, 32'h55AA_55AA, 1'b0, 32'hDEAD_BEEF);

        // Misaligned, out-of-range, and boundary addresses.
        access(1'b1, 1'b0, 32'h0000_000D, 32'h0,         1'b1, 32'h0000_0000);
        access(1'b1, 1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0000_0000);
        access(1'b0, 1'b1, 32'h0000_0400, 32'hBAD0_BAD0, 1'b1, 32'h0000_0000);
        check("illegal_write_blocked", mem[0], 32'hA500_0000);
        access(1'b0, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hA500_00FF);
        access(1'b0, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h55AA_55AA);

        // Both requesters held high from reset.
        do_reset();
`ifdef DMEM_ARB_RR_EN
        sb.push_back(mk(1'b0, 1'b0, 32'hA500_0004));
        sb.push_back(mk(1'b1, 1'b0, 32'hA500_0005));
        sb.push_back(mk(1'b0, 1'b0, 32'hA500_0004));
        sb.push_back(mk(1'b1, 1'b0, 32'hA500_0005));
`else
        for (int i = 0; i < 4; i++) sb.push_back(mk(1'b0, 1'b0, 32'hA500_0004));
`endif
        sb.push_back(mk(1'b1, 1'b0, 32'hA500_0005));
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0014, 32'h0);
        repeat (11) @(posedge clk);
        #1 req0_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 req1_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("arb_drained", sb.size(), 32'd0);

        // Reset in the middle of a port 0 write.
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("abort_ce_before", {31'd0, mem_ce_o}, 32'd1);
        check("abort_addr_before", mem_addr_o, 32'h0000_0030);
        #2;
        saved = done0_cnt;
        do_reset();
        check("abort_no_done0", done0_cnt, saved);
        check("abort_no_write", mem[12], 32'hA500_000C);
        access(1'b0, 1'b0, 32'h0000_0030, 32'h0, 1'b0, 32'hA500_000C);

        // req0 toggled while port 1 is busy is ignored.
        saved = done0_cnt;
        sb.push_back(mk(1'b1, 1'b0, 32'hA500_0009));
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0024, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
        @(negedge clk); #1 req0_i = 1'b0;
        @(posedge clk); #1 req0_i = 1'b1;
        #4 req0_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("toggled_req0_ignored", done0_cnt, saved);

        // req0 raised during port 1 ACCESS and held: served at the next IDLE.
        sb.push_back(mk(1'b1, 1'b0, 32'hA500_000A));
        sb.push_back(mk(1'b0, 1'b0, 32'hA500_0001));
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0028, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
        @(posedge clk); #1;
        check("held_req0_resp_done1", {31'd0, done1_o}, 32'd1);
        @(posedge clk); #1;
        check("held_req0_idle_no_ce", {31'd0, mem_ce_o}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("held_req0_access_ce", {31'd0, mem_ce_o}, 32'd1);
        @(posedge clk); #1;
        check("held_req0_done0", {31'd0, done0_o}, 32'd1);
        repeat (3) @(posedge clk);
        #1;

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
